// File: rtl/usbf_rx_crc_strip.sv
// Purpose : receive-side USB DATA packet CRC16 checker; strips the two trailing CRC bytes.
// Latency : payload byte N leaves one cycle after input byte N+2 is accepted; status one cycle after the last byte.
// Backpressure: none; every input byte is consumed and every valid_o beat must be taken downstream.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   rx_data_i/rx_valid_i    received byte stream (PID already removed)
//   rx_last_i               marks the final byte (second CRC byte) when rx_valid_i is high
//   rx_abort_i              PHY error: discard the packet in flight
//   data_o/valid_o/last_o   payload stream with the CRC bytes removed
//   done_o                  one-cycle pulse, packet complete and crc_err_o updated
//   crc_err_o               status of the last completed packet, held until the next done_o
//   err_count_o             saturating CRC error count when USBF_CRC_ERR_COUNT_EN is defined, else 0
//
// Build option: define USBF_CRC_ERR_COUNT_EN to build the error counter.
module usbf_rx_crc_strip (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  input  logic       rx_last_i,
  input  logic       rx_abort_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       last_o,
  output logic       done_o,
  output logic       crc_err_o,
  output logic [7:0] err_count_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD1 = 2'd1;
  localparam logic [1:0] ST_HOLD2 = 2'd2;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), data consumed LSB first as on the wire.
  function automatic logic [15:0] usbf_crc16(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  logic [1:0]  state_q;
  logic [15:0] crc_q;
  logic [7:0]  h0_q;
  logic [7:0]  h1_q;

  logic [15:0] crc_base;
  logic [15:0] crc_next;
  logic        accept;
  logic        pkt_end;
  logic        pkt_err;

  always_comb begin
    // The first byte of a packet starts from the seed rather than the stale register.
    crc_base = (state_q == ST_IDLE) ? 16'hFFFF : crc_q;
    crc_next = usbf_crc16(crc_base, rx_data_i);
    accept   = rx_valid_i && !rx_abort_i;
    pkt_end  = accept && rx_last_i;
    // A packet ending on its first byte cannot carry a CRC at all.
    pkt_err  = (state_q == ST_IDLE) ? 1'b1 : (crc_next != 16'hB001);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      crc_q     <= 16'hFFFF;
      h0_q      <= 8'h00;
      h1_q      <= 8'h00;
      data_o    <= 8'h00;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      done_o    <= 1'b0;
      crc_err_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      done_o  <= 1'b0;
      if (rx_abort_i) begin
        // Held bytes are simply forgotten; status from the previous packet stays.
        state_q <= ST_IDLE;
      end else if (rx_valid_i) begin
        crc_q <= crc_next;
        h1_q  <= rx_data_i;
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HOLD1;
          end
          ST_HOLD1: begin
            h0_q    <= h1_q;
            state_q <= ST_HOLD2;
          end
          ST_HOLD2: begin
            data_o  <= h0_q;
            valid_o <= 1'b1;
            h0_q    <= h1_q;
            last_o  <= rx_last_i;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
        if (rx_last_i) begin
          state_q   <= ST_IDLE;
          done_o    <= 1'b1;
          crc_err_o <= pkt_err;
        end
      end
    end
  end

`ifdef USBF_CRC_ERR_COUNT_EN
  logic [7:0] err_count_q;

  // Updates on the same edge as done_o so the count and status line up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_count_q <= 8'h00;
    end else if (pkt_end && pkt_err && (err_count_q != 8'hFF)) begin
      err_count_q <= err_count_q + 8'd1;
    end
  end

  assign err_count_o = err_count_q;
`else
  assign err_count_o = 8'h00;
`endif

  // Only the packet-end qualifier matters to the counter; keep the default build tidy.
  logic unused_ok;
  assign unused_ok = pkt_end;

endmodule

// File: tb/tb_usbf_rx_crc_strip.sv
`timescale 1ns/1ps
module tb_usbf_rx_crc_strip;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic       rx_abort;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       done;
  logic       crc_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  usbf_rx_crc_strip dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_last_i   (rx_last),
    .rx_abort_i  (rx_abort),
    .data_o      (data),
    .valid_o     (valid),
    .last_o      (last),
    .done_o      (done),
    .crc_err_o   (crc_err),
    .err_count_o (err_count)
  );

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] dat; logic lst; int due; } beat_t;
  typedef struct { logic err; logic [7:0] cnt; logic has_last; int due; } done_t;

  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  beat_t      beat_q[$];
  done_t      done_q[$];
  beat_t      mon_b;
  done_t      mon_d;
  logic       mon_en = 1'b0;
  logic       exp_status = 1'b0;
  logic [7:0] exp_cnt = 8'h00;
  logic [7:0] mdl_cnt = 8'h00;

`ifdef USBF_CRC_ERR_COUNT_EN
  localparam logic [7:0] CNT_ONE = 8'd1;
  localparam logic [7:0] CNT_SAT = 8'hFF;
`else
  localparam logic [7:0] CNT_ONE = 8'd0;
  localparam logic [7:0] CNT_SAT = 8'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Non-reflected long division over bits in wire order (LSB first per byte),
  // then reflected and inverted: the 16-bit value transmitted low byte first.
  function automatic logic [15:0] ref_crc(input bq_t b, input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic        top;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        top = c[15] ^ b[k][i];
        c = {c[14:0], 1'b0};
        if (top) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  function automatic bq_t with_crc(input bq_t p);
    bq_t q;
    logic [15:0] c;
    q = p;
    c = ref_crc(p, p.size());
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  task automatic drive(input logic [7:0] d, input logic v, input logic l, input logic a);
    @(posedge clk);
    #1;
    rx_data  = d;
    rx_valid = v;
    rx_last  = l;
    rx_abort = a;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends a packet; abort_at >= 0 replaces that byte with an aborting beat and ends the packet.
  task automatic send_pkt(input bq_t b, input int abort_at, input bit gaps);
    int          n;
    logic [15:0] c;
    logic        err;
    n = b.size();
    for (int j = 0; j < n; j++) begin
      if (gaps && ($urandom_range(0, 2) == 0))
        repeat ($urandom_range(1, 3)) drive(8'($urandom), 1'b0, 1'($urandom), 1'b0);
      if (j == abort_at) begin
        drive(b[j], 1'b1, 1'b0, 1'b1);
        return;
      end
      drive(b[j], 1'b1, (j == n - 1), 1'b0);
      if (j >= 2) beat_q.push_back('{b[j-2], (j == n - 1), cyc + 1});
      if (j == n - 1) begin
        if (n == 1) begin
          err = 1'b1;
        end else begin
          c   = ref_crc(b, n - 2);
          err = !((b[n-2] == c[7:0]) && (b[n-1] == c[15:8]));
        end
`ifdef USBF_CRC_ERR_COUNT_EN
        if (err && (mdl_cnt != 8'hFF)) mdl_cnt = mdl_cnt + 8'd1;
`endif
        done_q.push_back('{err, mdl_cnt, (n >= 3), cyc + 1});
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (valid) begin
        if (beat_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          mon_b = beat_q.pop_front();
          check("beat_data", data, mon_b.dat);
          check("beat_last", last, mon_b.lst);
          check("beat_cycle", cyc, mon_b.due);
        end
      end else begin
        check("last_without_valid", last, 1'b0);
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_d = done_q.pop_front();
          check("done_status", crc_err, mon_d.err);
          check("done_count", err_count, mon_d.cnt);
          check("done_cycle", cyc, mon_d.due);
          check("done_with_last", valid & last, mon_d.has_last);
          exp_status = mon_d.err;
          exp_cnt    = mon_d.cnt;
        end
      end else begin
        check("status_hold", crc_err, exp_status);
        check("count_hold", err_count, exp_cnt);
      end
    end
  end

  initial begin
    bq_t p;
    bq_t q;
    int  plen;
    int  pos;

    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0; rx_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_last", last, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_crc_err", crc_err, 1'b0);
    check("reset_err_count", err_count, 8'h00);
    rst = 1'b0;
    mon_en = 1'b1;

    // zero-length packet: CRC of nothing is 00 00
    p = '{8'h00, 8'h00};
    send_pkt(p, -1, 1'b0);
    idle(3);

    // four-byte payload with correct CRC, back-to-back with a corrupted copy
    p = '{8'h00, 8'h01, 8'h02, 8'h03};
    q = with_crc(p);
    send_pkt(q, -1, 1'b0);
    q[2] = q[2] ^ 8'h01;
    send_pkt(q, -1, 1'b0);
    idle(3);
    check("count_after_one_bad", err_count, CNT_ONE);

    // single-byte packet
    p = '{8'h5A};
    send_pkt(p, -1, 1'b0);
    idle(2);

    // abort with a valid byte after three bytes, then a good zero-length packet
    p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    q = with_crc(p);
    send_pkt(q, 3, 1'b0);
    p = '{8'h00, 8'h00};
    send_pkt(p, -1, 1'b0);
    idle(3);
    check("status_after_abort_good", crc_err, 1'b0);

    // randomized mix with gaps and aborts
    for (int k = 0; k < 200; k++) begin
      p = {};
      plen = $urandom_range(0, 10);
      for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
      q = with_crc(p);
      if ($urandom_range(0, 9) == 0) q = '{8'($urandom)};
      if ($urandom_range(0, 3) == 0) begin
        pos = $urandom_range(0, q.size() - 1);
        q[pos] = q[pos] ^ (8'h01 << $urandom_range(0, 7));
      end
      if ($urandom_range(0, 9) == 0) send_pkt(q, $urandom_range(0, q.size() - 1), 1'b1);
      else                           send_pkt(q, -1, 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    // reset in the middle of a packet
    mon_en = 1'b0;
    drive(8'hAA, 1'b1, 1'b0, 1'b0);
    drive(8'h55, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midreset_data", data, 8'h00);
    check("midreset_valid", valid, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_crc_err", crc_err, 1'b0);
    check("midreset_err_count", err_count, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat_q = {};
    done_q = {};
    exp_status = 1'b0;
    exp_cnt = 8'h00;
    mdl_cnt = 8'h00;
    mon_en = 1'b1;
    p = '{8'h00, 8'h00};
    send_pkt(p, -1, 1'b0);
    idle(2);

    // 300 bad packets to drive the counter into saturation
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) begin
        q = '{8'($urandom)};
      end else begin
        p = {};
        plen = $urandom_range(0, 3);
        for (int i = 0; i < plen; i++) p.push_back(8'($urandom));
        q = with_crc(p);
        pos = $urandom_range(0, q.size() - 1);
        q[pos] = q[pos] ^ (8'h01 << $urandom_range(0, 7));
      end
      send_pkt(q, -1, 1'b1);
    end
    idle(4);
    check("count_saturated", err_count, CNT_SAT);
    check("status_after_bad_run", crc_err, 1'b1);

    idle(6);
    check("beats_pending", beat_q.size(), 0);
    check("dones_pending", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
